// File: rtl/count_seq_ctrl_if.sv
// Command/status bundle between a host sequencer and count_seq_ctrl.
// The host drives the command side; the controller drives the count and status side.
interface count_seq_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int REPS_W = 4
);
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  limit;
    logic [REPS_W-1:0] reps;
    logic [WIDTH-1:0]  q;
    logic [REPS_W-1:0] pass_cnt;
    logic              tick;
    logic              done;
    logic              aborted;
    logic              busy;

    modport master (
        output start, abort, limit, reps,
        input  q, pass_cnt, tick, done, aborted, busy
    );

    modport slave (
        input  start, abort, limit, reps,
        output q, pass_cnt, tick, done, aborted, busy
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencing controller: runs a 0..limit counter for a latched number of passes,
// with a terminal-count tick, a one-cycle done pulse and abort support.
module count_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int REPS_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    count_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  limit_r;
    logic [WIDTH-1:0]  q_r;
    logic [REPS_W-1:0] reps_r;
    logic [REPS_W-1:0] pass_r;
    logic              aborted_r;
    logic              tick_c, done_c, busy_c;
    logic              accept, at_term, last_pass;

    // Abort has priority over start, so a simultaneous request is simply dropped.
    assign accept    = (state == IDLE) && bus.start && !bus.abort;
    assign at_term   = (q_r == limit_r);
    assign last_pass = ((pass_r + REPS_W'(1)) == reps_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (bus.reps == '0) ? DONE : RUN;
            RUN:  if (bus.abort || (at_term && last_pass)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick_c = 1'b0;
        done_c = 1'b0;
        busy_c = 1'b0;
        case (state)
            RUN: begin
                tick_c = at_term;
                busy_c = 1'b1;
            end
            DONE: begin
                done_c = 1'b1;
                busy_c = 1'b1;
            end
            default: ;
        endcase
    end

    // q/pass_cnt hold through DONE and IDLE; an abort freezes them at the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_r   <= '0;
            reps_r    <= '0;
            q_r       <= '0;
            pass_r    <= '0;
            aborted_r <= 1'b0;
        end else if (accept) begin
            limit_r   <= bus.limit;
            reps_r    <= bus.reps;
            q_r       <= '0;
            pass_r    <= '0;
            aborted_r <= 1'b0;
        end else if (state == RUN) begin
            if (bus.abort) begin
                aborted_r <= 1'b1;
            end else if (at_term) begin
                q_r    <= '0;
                pass_r <= pass_r + REPS_W'(1);
            end else begin
                q_r <= q_r + WIDTH'(1);
            end
        end
    end

    assign bus.q        = q_r;
    assign bus.pass_cnt = pass_r;
    assign bus.tick     = tick_c;
    assign bus.done     = done_c;
    assign bus.aborted  = aborted_r;
    assign bus.busy     = busy_c;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Randomized self-checking bench for count_seq_ctrl; expected outputs come from
// closed-form arithmetic on the cycle index since the accepted start.
module tb_count_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   exp_q = 0, exp_p = 0, exp_ab = 0;

    count_seq_ctrl_if #(.WIDTH(4), .REPS_W(4)) bus ();

    count_seq_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outs(input string tag, input int q, input int p, input int tk,
                              input int dn, input int ab, input int bs);
        check({tag, ".q"},        32'(bus.q),        q);
        check({tag, ".pass_cnt"}, 32'(bus.pass_cnt), p);
        check({tag, ".tick"},     32'(bus.tick),     tk);
        check({tag, ".done"},     32'(bus.done),     dn);
        check({tag, ".aborted"},  32'(bus.aborted),  ab);
        check({tag, ".busy"},     32'(bus.busy),     bs);
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the IDLE cycle after DONE.
    // ab < 0: no abort; otherwise abort is asserted in RUN cycle index ab (0-based).
    task automatic run_seq(input string tag, input int lim, input int rp, input int ab);
        int total, end_k, t, q, p;
        total = rp * (lim + 1);
        end_k = (ab >= 0) ? ab + 1 : total;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.limit = 4'(lim);
        bus.reps  = 4'(rp);
        for (int k = 1; k <= end_k + 2; k++) begin
            @(negedge clk);
            if (k <= end_k) begin
                t = k - 1;
                q = t % (lim + 1);
                p = t / (lim + 1);
                check_outs({tag, ".run"}, q, p, (q == lim) ? 1 : 0, 0, 0, 1);
            end else begin
                if (ab >= 0) begin
                    q = ab % (lim + 1);
                    p = ab / (lim + 1);
                end else begin
                    q = 0;
                    p = rp;
                end
                if (k == end_k + 1) begin
                    check_outs({tag, ".done"}, q, p, 0, 1, (ab >= 0) ? 1 : 0, 1);
                    done_cyc = cyc;
                end else begin
                    check_outs({tag, ".idle"}, q, p, 0, 0, (ab >= 0) ? 1 : 0, 0);
                end
                exp_q  = q;
                exp_p  = p;
                exp_ab = (ab >= 0) ? 1 : 0;
            end
            // Commands issued while busy must have no effect.
            if (k <= end_k + 1) begin
                bus.start = 1'($urandom);
                bus.limit = 4'($urandom);
                bus.reps  = 4'($urandom);
                bus.abort = (k <= end_k) ? ((k - 1 == ab) ? 1'b1 : 1'b0) : 1'($urandom);
            end else begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
            end
        end
    endtask

    task automatic idle_cycle(input string tag, input logic st, input logic ab);
        bus.start = st;
        bus.abort = ab;
        bus.limit = 4'($urandom);
        bus.reps  = 4'($urandom);
        @(negedge clk);
        check_outs(tag, exp_q, exp_p, 0, 0, exp_ab, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        int lim, rp, ab, prev;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.limit = '0;
        bus.reps  = '0;
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 0, 0, 0, 0, 0, 0);

        run_seq("basic", 3, 2, -1);
        run_seq("lim0", 0, 4, -1);
        run_seq("lim15", 15, 1, -1);
        run_seq("reps0", 2, 0, -1);
        idle_cycle("gap", 1'b0, 1'b0);
        run_seq("abort_mid", 7, 2, 12);
        run_seq("abort_final", 3, 2, 7);
        idle_cycle("start_abort", 1'b1, 1'b1);
        idle_cycle("start_abort2", 1'b0, 1'b0);

        run_seq("b2b_a", 3, 0, -1);
        prev = done_cyc;
        run_seq("b2b_b", 9, 0, -1);
        check("b2b_done_gap", 32'(done_cyc - prev), 2);
        run_seq("b2b_c", 1, 3, -1);

        // Asynchronous reset in the middle of a run: q=2 on the first pass.
        bus.start = 1'b1;
        bus.limit = 4'd5;
        bus.reps  = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre.q", 32'(bus.q), 2);
        #2 rst = 1'b1;
        #1 check_outs("rst_async", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q = 0; exp_p = 0; exp_ab = 0;
        idle_cycle("rst_idle1", 1'b0, 1'b0);
        idle_cycle("rst_idle2", 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            lim = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
            rp  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
            ab  = -1;
            if (rp > 0 && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(0, rp * (lim + 1) - 1));
            run_seq("rand", lim, rp, ab);
            repeat ($urandom_range(0, 2)) idle_cycle("rand_idle", 1'b0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Sequencing controller for the 4-bit counter datapath. It accepts a start command with a terminal value and a pass count, then runs a synchronous counter from 0 to the terminal value that many times. It emits a tick at each terminal count and a single-cycle done at the end, and supports abort. It sits between a host/control FSM and any logic that needs a bounded, repeatable count sequence. It replaces free-running ripple counting wherever a deterministic start/stop is required.

## Interface
- WIDTH, 4, counter width in bits
- REPS_W, 4, width of pass-count field
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command request; sampled only in IDLE
- abort  input  1  terminate current sequence; sampled only in RUN
- limit  input  WIDTH  terminal count, latched on accepted start
- reps  input  REPS_W  number of passes, latched on accepted start
- q  output  WIDTH  current count
- pass_cnt  output  REPS_W  number of completed passes in the current sequence
- tick  output  1  high for the cycle in which q equals the latched limit in RUN
- done  output  1  one-cycle pulse at the end of a sequence (normal or aborted)
- aborted  output  1  qualifies done; high with done when the sequence ended by abort
- busy  output  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE. Two-bit state register.
- IDLE:
  - start=1 and abort=0: latch limit into limit_r and reps into reps_r; clear q and pass_cnt.
    - reps=0: go to DONE; no counting, no tick.
    - Otherwise: go to RUN.
  - start=1 and abort=1 in the same cycle: abort wins; start is dropped and the state stays IDLE.
- RUN:
  - q<limit_r: q increments by 1.
  - q==limit_r: tick=1; q wraps to 0; pass_cnt increments.
    - The new pass_cnt equals reps_r: go to DONE.
  - limit_r=0: q stays 0, tick is high every RUN cycle, and each cycle is one pass.
- Abort in RUN: go to DONE; set aborted; freeze q and pass_cnt at their values before that edge. If abort coincides with the final terminal count, abort still wins: aborted=1, and pass_cnt does not take the final increment.
- DONE: done=1 for exactly one cycle; aborted is valid in the same cycle; then go to IDLE. start in DONE is ignored.
- start while busy=1 is ignored, and limit/reps changes while busy have no effect.
- Arithmetic:
  - q and pass_cnt are unsigned and never exceed limit_r and reps_r respectively.
  - limit=2^WIDTH-1 is legal; q wraps to 0 with no carry out.
- tick and done are decoded from registered state/q/limit_r only. No input feeds an output combinationally.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE; q=0; pass_cnt=0; tick=0; done=0; aborted=0; busy=0; limit_r=0; reps_r=0.
- Reset mid-sequence: returns to IDLE with all of the above values. No done pulse is issued.
- Start is accepted at edge E0: the first RUN cycle follows E0 with q=0 and busy=1.
- Sequence length: RUN lasts reps×(limit+1) cycles. The DONE cycle immediately follows the last RUN cycle. IDLE, busy=0, follows DONE.
- Start-to-done latency: reps×(limit+1)+1 cycles after E0. For reps=0, done is high in the first cycle after E0.
- Back-to-back throughput: a new start can be accepted at the edge that ends the IDLE cycle following DONE. Minimum gap between done pulses is 2 cycles.
- Abort sampled at edge Ea in RUN: DONE (done=1, aborted=1) in the cycle after Ea.
- aborted holds its value until the next accepted start or reset. It is meaningful only with done.

## Test plan
- Reset behaviour: assert rst mid-RUN (limit=5, reps=3, q=2) → all outputs 0 asynchronously, state IDLE, no done pulse.
- Basic sequence: start with limit=3, reps=2 →
  - q sequence 0,1,2,3,0,1,2,3;
  - tick on both 3s;
  - pass_cnt 0→1→2;
  - done=1 and aborted=0 in cycle 9 after acceptance;
  - busy low the following cycle.
- Edge values:
  - limit=0, reps=4 → tick high 4 consecutive cycles, q=0 throughout, done in cycle 5.
  - limit=15, reps=1 → q counts 0..15 and wraps to 0, done in cycle 17.
  - reps=0 → done in cycle 1, no tick.
- Abort:
  - limit=7, reps=2, abort while q=4 on pass 1 → done=1, aborted=1 the next cycle; q=4 and pass_cnt=1 frozen.
  - Abort on the final terminal-count cycle → aborted=1, pass_cnt=1.
- Ignored commands:
  - start pulses during RUN and DONE with different limit/reps → no effect on the sequence.
  - start and abort together in IDLE → stays IDLE.
- Back-to-back: second start in the IDLE cycle right after DONE → accepted; new limit/reps latched; the done pulses are exactly 2 cycles apart for reps=0 runs.
